// File: rtl/dds_pkg.sv
// dds_pkg: shared key-conditioning constants for the DDS control path.
package dds_pkg;
    localparam int   DEBOUNCE_CYCLES_DEF = 1000000;
    localparam logic KEY_PRESSED         = 1'b0;
    localparam logic KEY_RELEASED        = 1'b1;
endpackage

// File: rtl/key_filter_1ch.sv
// key_filter_1ch: one key's synchroniser, counter debounce and press-edge strobe.
module key_filter_1ch
    import dds_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic key_in,
    output logic key_out,
    output logic edge_n
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             s1_q, s2_q, out_q, out_d, dly_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mismatch, done;

    // Any sample agreeing with the accepted level restarts the count; the
    // accept at the terminal count also clears it, so it never wraps.
    always_comb begin
        mismatch = s2_q != out_q;
        done     = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
        cnt_d    = (!mismatch || done) ? '0 : cnt_q + CNT_W'(1);
        out_d    = (mismatch && done) ? s2_q : out_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q  <= KEY_RELEASED;
            s2_q  <= KEY_RELEASED;
            out_q <= KEY_RELEASED;
            dly_q <= KEY_RELEASED;
            cnt_q <= '0;
        end else begin
            s1_q  <= key_in;
            s2_q  <= s1_q;
            out_q <= out_d;
            dly_q <= out_q;
            cnt_q <= cnt_d;
        end
    end

    assign key_out = out_q;
    assign edge_n  = ~(dly_q == KEY_RELEASED && out_q == KEY_PRESSED);
endmodule

// File: rtl/key_debounce_edge.sv
// key_debounce_edge: NUM_KEYS independent active-low key conditioners.
module key_debounce_edge
    import dds_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] edge_n
);
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_filter_1ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .nrst   (nrst),
            .key_in (key_in[g]),
            .key_out(key_out[g]),
            .edge_n (edge_n[g])
        );
    end
endmodule

// File: tb/tb_key_debounce_edge.sv
// tb_key_debounce_edge: directed scenarios plus random key activity against a window model.
module tb_key_debounce_edge;
    localparam int NK = 3;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_out, edge_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: raw input reaches the filter two edges late; the level flips
    // once the last DC filter samples all disagree with it.
    logic [1:0]    pipe [NK];
    bit            win  [NK][$];
    logic [NK-1:0] out_m, edge_m;

    always #5 clk = ~clk;

    key_debounce_edge #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .key_in (key_in),
        .key_out(key_out),
        .edge_n (edge_n)
    );

    task automatic mreset();
        for (int k = 0; k < NK; k++) begin
            pipe[k] = '1;
            win[k].delete();
        end
        out_m  = '1;
        edge_m = '1;
    endtask

    task automatic mstep();
        edge_m = '1;
        for (int k = 0; k < NK; k++) begin
            bit ok;
            win[k].push_back(pipe[k][1]);
            if (win[k].size() > DC) void'(win[k].pop_front());
            pipe[k] = {pipe[k][0], key_in[k]};
            ok = win[k].size() == DC;
            foreach (win[k][i]) if (win[k][i] == out_m[k]) ok = 1'b0;
            if (ok) begin
                out_m[k] = ~out_m[k];
                if (out_m[k] == 1'b0) edge_m[k] = 1'b0;
            end
        end
    endtask

    task automatic chk();
        checks++;
        assert (key_out === out_m) else begin
            errors++;
            $error("FAIL key_out cyc=%0d obs=%b exp=%b", cyc, key_out, out_m);
        end
        checks++;
        assert (edge_n === edge_m) else begin
            errors++;
            $error("FAIL edge_n cyc=%0d obs=%b exp=%b", cyc, edge_n, edge_m);
        end
    endtask

    task automatic tick(input logic [NK-1:0] k, input logic r);
        @(negedge clk);
        key_in = k;
        nrst   = r;
        @(posedge clk);
        cyc++;
        if (nrst) mstep(); else mreset();
        #1 chk();
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int t0, fall, fall2, nstr, act;
        logic [NK-1:0] rk;
        int hold [NK];
        mreset();
        repeat (3) tick(3'b111, 1'b0);
        repeat (50) tick(3'b111, 1'b1);

        // Single press on key 0
        t0 = cyc + 1; fall = -1; nstr = 0;
        repeat (30) begin
            tick(3'b110, 1'b1);
            if (fall < 0 && key_out[0] == 1'b0) fall = cyc;
            if (edge_n == 3'b110) nstr++;
        end
        expect_int("press0_latency", fall - t0 + 1, DC + 2);
        expect_int("press0_strobes", nstr, 1);

        // Key 1 bounces, then settles pressed
        act = 0;
        for (int i = 0; i < 40; i++) begin
            tick({1'b1, ((i / 3) % 2) ? 1'b1 : 1'b0, 1'b0}, 1'b1);
            if (key_out[1] == 1'b0 || edge_n[1] == 1'b0) act++;
        end
        expect_int("bounce1_quiet", act, 0);
        t0 = cyc + 1; fall = -1; nstr = 0;
        repeat (20) begin
            tick(3'b100, 1'b1);
            if (fall < 0 && key_out[1] == 1'b0) fall = cyc;
            if (edge_n == 3'b101) nstr++;
        end
        expect_int("settle1_latency", fall - t0 + 1, DC + 2);
        expect_int("settle1_strobes", nstr, 1);

        // Release key 0: symmetric delay, no strobe
        t0 = cyc + 1; fall = -1; act = 0;
        repeat (20) begin
            tick(3'b101, 1'b1);
            if (fall < 0 && key_out[0] == 1'b1) fall = cyc;
            if (edge_n != 3'b111) act++;
        end
        expect_int("release0_latency", fall - t0 + 1, DC + 2);
        expect_int("release0_strobes", act, 0);

        // Keys 0 and 2 pressed together
        repeat (20) tick(3'b111, 1'b1);
        fall = -1; fall2 = -1; nstr = 0;
        repeat (20) begin
            tick(3'b010, 1'b1);
            if (fall < 0 && key_out[0] == 1'b0) fall = cyc;
            if (fall2 < 0 && key_out[2] == 1'b0) fall2 = cyc;
            if (edge_n == 3'b010) nstr++;
        end
        expect_int("dual_same_edge", fall2 - fall, 0);
        expect_int("dual_strobes", nstr, 1);

        // Asynchronous reset while key 2 is mid-count
        repeat (20) tick(3'b111, 1'b1);
        repeat (7) tick(3'b011, 1'b1);
        @(negedge clk);
        #2 nrst = 1'b0;
        mreset();
        #1 chk();
        repeat (3) tick(3'b011, 1'b0);
        t0 = cyc + 1; fall = -1; nstr = 0;
        repeat (20) begin
            tick(3'b011, 1'b1);
            if (fall < 0 && key_out[2] == 1'b0) fall = cyc;
            if (edge_n == 3'b011) nstr++;
        end
        expect_int("rst_restart_latency", fall - t0 + 1, DC + 2);
        expect_int("rst_restart_strobes", nstr, 1);

        // Random key activity, holds both shorter and longer than DC
        rk = '1;
        for (int k = 0; k < NK; k++) hold[k] = 0;
        repeat (1500) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    rk[k]   = 1'($urandom_range(0, 1));
                    hold[k] = $urandom_range(1, 3 * DC);
                end
                hold[k]--;
            end
            tick(rk, $urandom_range(0, 299) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
